// File: rtl/sift_pkg.sv
// Shared constants and encodings for the SIFT core.
// Holds the image geometry and the stream loader state encoding.
package sift_pkg;

  localparam int IMG_ROWS      = 480;
  localparam int IMG_COLS      = 640;
  localparam int PIX_W         = 8;
  localparam int ROW_W         = IMG_COLS * PIX_W;
  localparam int ADDR_W        = 9;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_ROW = ROW_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } loader_state_t;

endpackage

// File: rtl/row_packer.sv
// Shift-register row assembler: packs incoming words LSB-first into one row
// and flags the accept that completes the row.
module row_packer #(
  parameter int WORD_W        = sift_pkg::WORD_W,
  parameter int ROW_W         = sift_pkg::ROW_W,
  parameter int WORDS_PER_ROW = sift_pkg::WORDS_PER_ROW,
  parameter int CNT_W         = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [WORD_W-1:0] in_data,
  output logic              row_full,
  output logic [ROW_W-1:0]  packed_row
);

  logic [ROW_W-1:0] row_buf;
  logic [CNT_W-1:0] word_cnt;
  logic             last_word;

  // packed_row already includes the word being accepted, so the commit
  // register can capture a complete row in the same cycle.
  assign packed_row = {in_data, row_buf[ROW_W-1:WORD_W]};
  assign last_word  = (word_cnt == CNT_W'(WORDS_PER_ROW - 1));
  assign row_full   = accept && last_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_buf  <= '0;
      word_cnt <= '0;
    end else if (accept) begin
      row_buf  <= packed_row;
      word_cnt <= last_word ? '0 : word_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/img_stream_loader.sv
// Loads a raw image from a 16-bit word stream into the row-wide image SRAM
// and pulses done once the last row has been committed.
module img_stream_loader #(
  parameter int ROWS          = sift_pkg::IMG_ROWS,
  parameter int WORD_W        = sift_pkg::WORD_W,
  parameter int ROW_W         = sift_pkg::ROW_W,
  parameter int WORDS_PER_ROW = ROW_W / WORD_W,
  parameter int ADDR_W        = sift_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ROW_W-1:0]  mem_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] row_cnt
);

  import sift_pkg::*;

  loader_state_t    state, next_state;
  logic             accept;
  logic             row_full;
  logic             last_row;
  logic [ROW_W-1:0] packed_row;

  assign accept   = in_valid && (state != FLUSH);
  assign last_row = (row_cnt == ADDR_W'(ROWS - 1));

  row_packer #(
    .WORD_W        (WORD_W),
    .ROW_W         (ROW_W),
    .WORDS_PER_ROW (WORDS_PER_ROW),
    .CNT_W         (ADDR_W)
  ) u_row_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .in_data    (in_data),
    .row_full   (row_full),
    .packed_row (packed_row)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (row_full && last_row) next_state = FLUSH;
      end
      FLUSH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Commit registers are separate from the packer's shift register so the
  // next row can start filling in the cycle right after a row completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      row_cnt  <= '0;
    end else begin
      mem_we <= row_full;
      if (row_full) begin
        mem_din  <= packed_row;
        mem_addr <= row_cnt;
        row_cnt  <= row_cnt + 1'b1;
      end else if (state == FLUSH) begin
        row_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_img_stream_loader.sv
// Scoreboard bench for img_stream_loader on a reduced-height frame: expected
// row writes are queued as words are driven and popped on each mem_we.
module tb_img_stream_loader;

  localparam int TB_ROWS     = 12;
  localparam int WPR         = 320;
  localparam int FRAME_WORDS = TB_ROWS * WPR;

  typedef struct {
    logic [8:0]    addr;
    logic [5119:0] din;
    bit            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          mem_we;
  logic [8:0]    mem_addr;
  logic [5119:0] mem_din;
  logic          busy;
  logic          done;
  logic [8:0]    row_cnt;

  exp_t          sb[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;
  int            m_state     = 0;
  int            m_word      = 0;
  int            m_rowcnt    = 0;
  logic [5119:0] m_buf       = '0;
  int            cur_mode    = 0;
  bit            full_rate   = 1'b0;
  bit            first_we    = 1'b0;
  int            frame_start = 0;
  int            prev_we_cyc = 0;
  int            done_cnt    = 0;

  img_stream_loader #(.ROWS(TB_ROWS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .busy     (busy),
    .done     (done),
    .row_cnt  (row_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic checkWrite();
    exp_t          e;
    logic [5119:0] all5a;
    int            a;
    all5a = {320{16'h5A5A}};
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    a = int'(e.addr);
    checkOutput("we_addr", mem_addr, e.addr);
    checkOutput("we_done", done, e.last);
    checkOutput("we_row_cnt", row_cnt, e.addr + 9'd1);
    for (int k = 0; k < WPR; k++)
      checkOutput("din_word", mem_din[16*k +: 16], e.din[16*k +: 16]);
    if (cur_mode == 1 || (cur_mode == 2 && a != 0)) begin
      checkOutput("row_first_word", mem_din[15:0], 16'((WPR * a) & 16'hFFFF));
      checkOutput("row_last_word", mem_din[5119:5104], 16'((WPR * a + 319) & 16'hFFFF));
    end
    if (cur_mode == 2 && a == 0) begin
      checkOutput("pix_even", mem_din[7:0], 8'hAA);
      checkOutput("pix_odd", mem_din[15:8], 8'hBB);
    end
    if (cur_mode == 3)
      checkOutput("din_all_5a", mem_din === all5a, 1);
    if (full_rate) begin
      if (first_we) checkOutput("row0_latency", cyc - frame_start, WPR);
      else          checkOutput("we_spacing", cyc - prev_we_cyc, WPR);
    end
    first_we    = 1'b0;
    prev_we_cyc = cyc;
  endtask

  // One clock: observe outputs #1 after the edge, then drive this cycle's
  // inputs and advance the reference model past the next edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d);
    exp_t e;
    logic acc;
    int   nxt;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_we) checkWrite();
    if (done) done_cnt++;
    checkOutput("busy", busy, m_state == 1);
    checkOutput("done", done, m_state == 2);
    checkOutput("row_cnt", row_cnt, m_rowcnt);
    in_valid = v;
    in_data  = d;
    acc = v && (m_state != 2);
    nxt = (m_state == 2) ? 0 : m_state;
    if (m_state == 2) m_rowcnt = 0;
    if (acc) begin
      if (m_state == 0) nxt = 1;
      m_buf = {d, m_buf[5119:16]};
      if (m_word == WPR - 1) begin
        e.addr = 9'(m_rowcnt);
        e.din  = m_buf;
        e.last = (m_rowcnt == TB_ROWS - 1);
        sb.push_back(e);
        m_word   = 0;
        m_rowcnt = m_rowcnt + 1;
        if (e.last) nxt = 2;
      end else begin
        m_word++;
      end
    end
    m_state = nxt;
  endtask

  task automatic doReset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    repeat (cycles) @(posedge clk);
    #1;
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_din_or", |mem_din, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_row_cnt", row_cnt, 0);
    rst_n    = 1'b1;
    m_state  = 0;
    m_word   = 0;
    m_rowcnt = 0;
    m_buf    = '0;
    sb.delete();
  endtask

  // mode 1: data = word index, 2: index with word 0 = BBAA, 3: all 5A5A.
  task automatic sendFrame(input int mode, input int duty, input int nwords, input bit late);
    int          n;
    logic        v;
    logic [15:0] d;
    n         = 0;
    cur_mode  = mode;
    full_rate = (duty >= 100);
    first_we  = 1'b1;
    done_cnt  = 0;
    while (n < nwords) begin
      v = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      case (mode)
        2:       d = (n == 0) ? 16'hBBAA : 16'(n);
        3:       d = 16'h5A5A;
        default: d = 16'(n);
      endcase
      applyStimulus(v, v ? d : 16'hC3C3);
      if (v && n == 0) frame_start = cyc;
      if (v) n++;
    end
    if (nwords == FRAME_WORDS) begin
      applyStimulus(late, 16'hFFFF);
      checkOutput("done_count", done_cnt, 1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    doReset(3);
    sendFrame(1, 100, FRAME_WORDS, 1'b0);
    sendFrame(1, 30, FRAME_WORDS, 1'b0);
    sendFrame(2, 100, FRAME_WORDS, 1'b0);
    sendFrame(1, 100, 1000, 1'b0);
    doReset(2);
    sendFrame(3, 100, FRAME_WORDS, 1'b0);
    sendFrame(1, 100, FRAME_WORDS, 1'b1);
    sendFrame(1, 100, FRAME_WORDS, 1'b1);
    sendFrame(1, 100, FRAME_WORDS, 1'b0);
    repeat (5) applyStimulus(1'b0, 16'h0);
    checkOutput("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
